// File: rtl/ro_scan_pkg.sv
// Shared types and constants for the ring-oscillator scan controller.
package ro_scan_pkg;

    localparam int IDX_W    = 4;
    localparam int MIN_WAIT = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WARMUP,
        S_GATE,
        S_REPORT,
        S_NEXT
    } state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Synchronises the muxed oscillator output, detects rising edges and counts them.
// RO_SCAN_SAT_EN defined: saturating counter; otherwise the counter wraps.
module ro_edge_counter #(
    parameter int COUNT_W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               en,
    input  logic               ro_in,
    output logic [COUNT_W-1:0] count_next,
    output logic               ovf_next
);

    localparam logic [COUNT_W-1:0] CNT_MAX = '1;

    logic               sync1, sync2, sync3;
    logic               rise;
    logic [COUNT_W-1:0] count;
    logic               ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= ro_in;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rise = sync2 & ~sync3;

    always_comb begin
        count_next = count;
        ovf_next   = ovf;
        if (clr) begin
            count_next = '0;
            ovf_next   = 1'b0;
        end else if (en && rise) begin
`ifdef RO_SCAN_SAT_EN
            if (count != CNT_MAX) count_next = count + COUNT_W'(1);
            if (count_next == CNT_MAX) ovf_next = 1'b1;
`else
            count_next = count + COUNT_W'(1);
            if (count == CNT_MAX) ovf_next = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= ovf_next;
        end
    end

endmodule

// File: rtl/ro_scan_controller.sv
// Walks the masked ring oscillators, gates an edge count on each one and streams
// (idx, count, ovf) results. Counter saturation is selected by RO_SCAN_SAT_EN.
//
// state  | meaning
// IDLE   | waiting for go_i
// SELECT | mux select settling, oscillator stopped
// WARMUP | oscillator running, counter cleared on the last cycle
// GATE   | counting synchronised rising edges
// REPORT | result presented, waiting for the handshake
// NEXT   | step to the next masked oscillator or finish the scan
module ro_scan_controller
    import ro_scan_pkg::*;
#(
    parameter int NUM_RO  = 16,
    parameter int COUNT_W = 24,
    parameter int GATE_W  = 20,
    parameter int WAIT_W  = 8
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      go_i,
    input  logic                      abort_i,
    input  logic [NUM_RO-1:0]         ro_mask_i,
    input  logic [4:0]                stage_cfg_i,
    input  logic [WAIT_W-1:0]         settle_i,
    input  logic [WAIT_W-1:0]         warmup_i,
    input  logic [GATE_W-1:0]         gate_i,
    input  logic                      ro_in_i,
    output logic [$clog2(NUM_RO)-1:0] sel_o,
    output logic                      start_o,
    output logic [4:0]                stage_o,
    output logic                      res_valid_o,
    input  logic                      res_ready_i,
    output logic [$clog2(NUM_RO)-1:0] res_idx_o,
    output logic [COUNT_W-1:0]        res_count_o,
    output logic                      res_ovf_o,
    output logic                      busy_o,
    output logic                      done_o
);

    localparam int SEL_W = $clog2(NUM_RO);
    localparam int TMR_W = (GATE_W > WAIT_W) ? GATE_W : WAIT_W;

    state_t              state, state_next;
    logic [TMR_W-1:0]    timer, timer_d;
    logic [SEL_W-1:0]    idx_d, first_idx, next_idx;
    logic                found_next;
    logic [NUM_RO-1:0]   mask_q;
    logic [WAIT_W-1:0]   settle_q, warmup_q;
    logic [GATE_W-1:0]   gate_q;
    logic                start_d, valid_d, busy_d, done_d;
    logic                load_res, latch_cfg;
    logic                cnt_clr, cnt_en;
    logic [COUNT_W-1:0]  cnt_next;
    logic                ovf_next;

    // A programmed length of 0 behaves as 1; the timer holds length-1 and exits at 0.
    function automatic logic [TMR_W-1:0] wait_load(input logic [TMR_W-1:0] len);
        return (len == '0) ? '0 : len - TMR_W'(MIN_WAIT);
    endfunction

    always_comb begin
        first_idx  = '0;
        next_idx   = '0;
        found_next = 1'b0;
        for (int i = NUM_RO - 1; i >= 0; i--) begin
            if (ro_mask_i[i]) first_idx = SEL_W'(i);
            if (mask_q[i] && (i > int'(sel_o))) begin
                next_idx   = SEL_W'(i);
                found_next = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_next;
            timer <= timer_d;
        end
    end

    always_comb begin
        state_next = state;
        timer_d    = (timer != '0) ? timer - TMR_W'(1) : timer;
        idx_d      = sel_o;
        if (abort_i) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_i && (ro_mask_i != '0)) begin
                        state_next = S_SELECT;
                        idx_d      = first_idx;
                        timer_d    = wait_load(TMR_W'(settle_i));
                    end
                end
                S_SELECT: begin
                    if (timer == '0) begin
                        state_next = S_WARMUP;
                        timer_d    = wait_load(TMR_W'(warmup_q));
                    end
                end
                S_WARMUP: begin
                    if (timer == '0) begin
                        state_next = S_GATE;
                        timer_d    = wait_load(TMR_W'(gate_q));
                    end
                end
                S_GATE: begin
                    if (timer == '0) state_next = S_REPORT;
                end
                S_REPORT: begin
                    if (res_valid_o && res_ready_i) state_next = S_NEXT;
                end
                S_NEXT: begin
                    if (found_next) begin
                        state_next = S_SELECT;
                        idx_d      = next_idx;
                        timer_d    = wait_load(TMR_W'(settle_q));
                    end else begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // Outputs are registered, so their next values derive from state_next.
    always_comb begin
        start_d   = (state_next == S_WARMUP) || (state_next == S_GATE);
        valid_d   = (state_next == S_REPORT);
        busy_d    = (state_next != S_IDLE);
        latch_cfg = !abort_i && (state == S_IDLE) && go_i;
        done_d    = !abort_i && (((state == S_IDLE) && go_i && (ro_mask_i == '0)) ||
                                 ((state == S_NEXT) && !found_next));
        load_res  = (state == S_GATE) && (state_next == S_REPORT);
        cnt_clr   = (state == S_WARMUP) && (timer == '0);
        cnt_en    = (state == S_GATE);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            sel_o       <= '0;
            start_o     <= 1'b0;
            stage_o     <= '0;
            res_valid_o <= 1'b0;
            res_idx_o   <= '0;
            res_count_o <= '0;
            res_ovf_o   <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            mask_q      <= '0;
            settle_q    <= '0;
            warmup_q    <= '0;
            gate_q      <= '0;
        end else begin
            sel_o       <= idx_d;
            start_o     <= start_d;
            res_valid_o <= valid_d;
            busy_o      <= busy_d;
            done_o      <= done_d;
            if (latch_cfg) begin
                mask_q   <= ro_mask_i;
                stage_o  <= stage_cfg_i;
                settle_q <= settle_i;
                warmup_q <= warmup_i;
                gate_q   <= gate_i;
            end
            // The counter's next value is what it holds after the last GATE cycle.
            if (load_res) begin
                res_idx_o   <= sel_o;
                res_count_o <= cnt_next;
                res_ovf_o   <= ovf_next;
            end
        end
    end

    ro_edge_counter #(
        .COUNT_W (COUNT_W)
    ) u_edge_counter (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .clr        (cnt_clr),
        .en         (cnt_en),
        .ro_in      (ro_in_i),
        .count_next (cnt_next),
        .ovf_next   (ovf_next)
    );

endmodule

// File: tb/tb_ro_scan_controller.sv
// Scoreboard bench for ro_scan_controller: scans push expected results, a monitor checks them.
`timescale 1ns/1ps
module tb_ro_scan_controller;

    localparam int CW    = 8;
    localparam int MAXC  = (1 << CW) - 1;
    localparam int LIMIT = 20000;

    logic          clk = 1'b0;
    logic          rst;
    logic          go, abort;
    logic [15:0]   mask;
    logic [4:0]    stage;
    logic [7:0]    settle, warmup;
    logic [19:0]   gate;
    logic          ro_in;
    logic [3:0]    sel;
    logic          start;
    logic [4:0]    stage_out;
    logic          valid;
    logic          ready = 1'b0;
    logic [3:0]    ridx;
    logic [CW-1:0] rcount;
    logic          rovf;
    logic          busy, done;

    ro_scan_controller #(
        .NUM_RO (16), .COUNT_W (CW), .GATE_W (20), .WAIT_W (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .go_i        (go),
        .abort_i     (abort),
        .ro_mask_i   (mask),
        .stage_cfg_i (stage),
        .settle_i    (settle),
        .warmup_i    (warmup),
        .gate_i      (gate),
        .ro_in_i     (ro_in),
        .sel_o       (sel),
        .start_o     (start),
        .stage_o     (stage_out),
        .res_valid_o (valid),
        .res_ready_i (ready),
        .res_idx_o   (ridx),
        .res_count_o (rcount),
        .res_ovf_o   (rovf),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Free-running oscillator; edges stay 3 ns off the 5 ns clock grid.
    int ro_half = 20;
    initial begin
        ro_in = 1'b0;
        #3;
        forever begin
            #(ro_half);
            ro_in = ~ro_in;
        end
    end

    typedef struct {
        int idx;
        int n0;
        int lo;
        int hi;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;
    int         start_rises = 0;
    int         lo_run = 0;
    int         hi_run = 0;
    int         rdy_mode = 0;
    int         vcyc = 0;
    logic [4:0] cur_stage = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Any true edge count within one of the nominal value, mapped through the counter mode.
    function automatic bit count_ok(input int n0, input logic [CW-1:0] c, input logic o);
        int ec;
        bit eo;
        for (int n = n0 - 1; n <= n0 + 1; n++) begin
            if (n < 0) continue;
`ifdef RO_SCAN_SAT_EN
            ec = (n >= MAXC) ? MAXC : n;
            eo = (n >= MAXC);
`else
            ec = n % (MAXC + 1);
            eo = (n > MAXC);
`endif
            if ((int'(c) == ec) && (o == eo)) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        #1;
        if (valid) vcyc++; else vcyc = 0;
        case (rdy_mode)
            1:       ready = 1'($urandom_range(0, 1));
            2:       ready = (vcyc > 50);
            default: ready = 1'b1;
        endcase
    end

    logic          pv = 1'b0, pr = 1'b0, pstart = 1'b0;
    logic [3:0]    pidx;
    logic [CW-1:0] pcnt;
    logic          povf;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (pv && !pr) begin
                check("stall_valid", valid, 1);
                check("stall_idx", ridx, pidx);
                check("stall_count", rcount, pcnt);
                check("stall_ovf", rovf, povf);
            end
            if (start && valid) check("start_during_report", start, 0);
            if (!busy) begin
                lo_run = 0;
                hi_run = 0;
            end else if (start) hi_run++;
            else if (!valid) lo_run++;
            if (start && !pstart) begin
                start_rises++;
                if (exp_q.size() == 0) check("unexpected_start", 1, 0);
                else begin
                    check("sel_at_start", sel, exp_q[0].idx);
                    check("stage_at_start", stage_out, cur_stage);
                end
            end
            if (valid && !pv) begin
                if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                else begin
                    e = exp_q.pop_front();
                    check("res_idx", ridx, e.idx);
                    check("select_cycles", lo_run, e.lo);
                    check("start_cycles", hi_run, e.hi);
                    checks++;
                    if (!count_ok(e.n0, rcount, rovf)) begin
                        errors++;
                        $display("FAIL res_count idx %0d got count %0d ovf %0d expected about %0d edges",
                                 e.idx, rcount, rovf, e.n0);
                    end
                end
                lo_run = 0;
                hi_run = 0;
            end
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 0);
                check("done_pending", exp_q.size(), 0);
            end
        end
        pv = valid; pr = ready; pidx = ridx; pcnt = rcount; povf = rovf; pstart = start;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input logic [15:0] m, input logic [4:0] st, input int s, input int w,
                            input int g, input int p, input int rmode, input bit extra_go);
        exp_t e;
        int   se, we, ge, d0, n;
        bit   first;
        se = (s == 0) ? 1 : s;
        we = (w == 0) ? 1 : w;
        ge = (g == 0) ? 1 : g;
        ro_half = p * 5;
        rdy_mode = rmode;
        mask = m; stage = st; settle = 8'(s); warmup = 8'(w); gate = 20'(g);
        cur_stage = st;
        tick(12);
        first = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (m[i]) begin
                e.idx = i;
                e.n0  = ge / p;
                e.lo  = first ? se : se + 1;
                e.hi  = we + ge;
                exp_q.push_back(e);
                first = 1'b0;
            end
        end
        d0 = done_cnt;
        go = 1'b1;
        tick(1);
        go = 1'b0;
        if (extra_go && m != 0) begin
            tick(1);
            go = 1'b1;
            tick(1);
            go = 1'b0;
        end
        n = 0;
        while (done_cnt == d0 && n < LIMIT) begin
            tick(1);
            n++;
        end
        if (n >= LIMIT) check("scan_timeout", n, 0);
        tick(4);
        check("done_once", done_cnt - d0, 1);
        check("results_left", exp_q.size(), 0);
        check("busy_after_done", busy, 0);
        exp_q.delete();
    endtask

    initial begin
        int s0, d0, n;
        rst = 1'b1; go = 1'b0; abort = 1'b0;
        mask = '0; stage = '0; settle = '0; warmup = '0; gate = '0;
        tick(3);
        check("rst_sel", sel, 0);
        check("rst_start", start, 0);
        check("rst_stage", stage_out, 0);
        check("rst_valid", valid, 0);
        check("rst_idx", ridx, 0);
        check("rst_count", rcount, 0);
        check("rst_ovf", rovf, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        tick(2);

        run_scan(16'h0001, 5'h15, 2, 4, 100, 4, 0, 1'b0);
        run_scan(16'h8421, 5'h0c, 1, 2, 60, 5, 0, 1'b1);
        run_scan(16'h0003, 5'h1f, 3, 1, 80, 4, 2, 1'b0);
        run_scan(16'h0010, 5'h07, 0, 0, 900, 3, 0, 1'b0);
        run_scan(16'h0200, 5'h0a, 1, 0, 0, 3, 1, 1'b0);
        run_scan(16'h4000, 5'h11, 2, 2, 600, 2, 0, 1'b0);

        // empty mask: done pulse, nothing started
        s0 = start_rises; d0 = done_cnt;
        mask = '0;
        go = 1'b1;
        tick(1);
        go = 1'b0;
        tick(20);
        check("zero_mask_done", done_cnt - d0, 1);
        check("zero_mask_start", start_rises - s0, 0);
        check("zero_mask_busy", busy, 0);

        // go together with abort in IDLE
        s0 = start_rises; d0 = done_cnt;
        mask = 16'h0001; settle = 8'd1; warmup = 8'd1; gate = 20'd10;
        go = 1'b1; abort = 1'b1;
        tick(1);
        go = 1'b0; abort = 1'b0;
        check("go_abort_busy", busy, 0);
        tick(30);
        check("go_abort_start", start_rises - s0, 0);
        check("go_abort_done", done_cnt - d0, 0);

        // abort in the middle of the gate window
        ro_half = 20; rdy_mode = 0;
        mask = 16'h0003; stage = 5'h05; cur_stage = 5'h05;
        settle = 8'd1; warmup = 8'd2; gate = 20'd200;
        begin
            exp_t e;
            e.idx = 0; e.n0 = 50; e.lo = 1; e.hi = 202;
            exp_q.push_back(e);
        end
        d0 = done_cnt;
        go = 1'b1;
        tick(1);
        go = 1'b0;
        n = 0;
        while (!start && n < 50) begin
            tick(1);
            n++;
        end
        if (n >= 50) check("abort_wait_start", n, 0);
        tick(20);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        exp_q.delete();
        check("abort_start", start, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        tick(20);
        check("abort_no_done", done_cnt - d0, 0);
        run_scan(16'h0003, 5'h05, 1, 2, 120, 4, 0, 1'b0);

        for (int k = 0; k < 8; k++) begin
            logic [15:0] m;
            int g;
            m = 16'($urandom_range(0, 65535) & $urandom_range(0, 65535) & $urandom_range(0, 65535));
            g = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : $urandom_range(3, 300);
            run_scan(m, 5'($urandom_range(0, 31)), $urandom_range(0, 5), $urandom_range(0, 5),
                     g, $urandom_range(3, 8), 1, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_scan_controller.md
# ro_scan_controller

Sequencer for the ring-oscillator characterisation array. It walks the 16 oscillators behind the 16:1 output mux, measures each oscillator's frequency by counting rising edges over a programmable gate window, and hands each result out on a valid/ready stream. It drives the shared `s1..s5` stage-select and `start` lines and the mux select, so only one oscillator runs during each measurement. It sits in the user project area alongside the oscillator instances and the output mux.

## Interface
Parameters:
- `NUM_RO`, 16: number of oscillators and mux inputs; must be a power of two.
- `COUNT_W`, 24: width of the edge counter and of the result.
- `GATE_W`, 20: width of the gate-length field.
- `WAIT_W`, 8: width of the settle-time and warm-up-time fields.

Ports:
- `wb_clk_i`, in, 1: the single clock for the block.
- `wb_rst_i`, in, 1: reset, asynchronous and active-high.
- `go_i`, in, 1: one-cycle pulse; starts a scan. Ignored while `busy_o` is high.
- `abort_i`, in, 1: level; returns the block to IDLE at the next clock.
- `ro_mask_i`, in, NUM_RO: bit i=1 means oscillator i is measured. Sampled when a scan starts.
- `stage_cfg_i`, in, 5: value driven on `s1..s5`. Sampled when a scan starts.
- `settle_i`, in, WAIT_W: number of cycles the mux select settles before `start` rises.
- `warmup_i`, in, WAIT_W: number of cycles after `start` rises before counting begins.
- `gate_i`, in, GATE_W: length of the counting window in cycles. 0 is treated as 1.
- `ro_in_i`, in, 1: muxed oscillator output. Asynchronous to `wb_clk_i`.
- `sel_o`, out, log2(NUM_RO): mux select.
- `start_o`, out, 1: shared oscillator enable.
- `stage_o`, out, 5: drives `s1..s5`.
- `res_valid_o`, out, 1: a result is available.
- `res_ready_i`, in, 1: the consumer accepts the result.
- `res_idx_o`, out, log2(NUM_RO): which oscillator the result belongs to.
- `res_count_o`, out, COUNT_W: measured edge count.
- `res_ovf_o`, out, 1: the counter reached its maximum value during the window.
- `busy_o`, out, 1: a scan is in progress.
- `done_o`, out, 1: one-cycle pulse when a scan completes normally.

## Operation
State machine states: IDLE, SELECT, WARMUP, GATE, REPORT, NEXT.
- **IDLE**: when `go_i` arrives, latch the mask, stage configuration, settle, warm-up and gate values. Set the index to the lowest set mask bit and go to SELECT. If the mask is all zero, pulse `done_o` and stay in IDLE.
- **SELECT**: drive `sel_o` with the index, hold `start_o` low, wait `settle` cycles, then go to WARMUP.
- **WARMUP**: drive `start_o` high, wait `warmup` cycles, then clear the counter and go to GATE.
- **GATE**: count synchronised rising edges of `ro_in_i` for `gate` cycles, then go to REPORT.
- **REPORT**: drive `start_o` low. Hold `res_valid_o` high with the index, count and overflow flag. When `res_valid_o && res_ready_i`, go to NEXT.
- **NEXT**: advance to the next set mask bit above the current index and go to SELECT. If no set bit remains, pulse `done_o` and go to IDLE. The index never wraps within a scan.
- Edge detection: two-flop synchroniser, a third flop, then rising-edge detect. Only edges whose detect pulse falls inside the GATE cycles are counted. Measurement is valid for f_ro < f_clk/2.
- Result outputs stay stable while `res_valid_o` is high and the consumer stalls.
- `abort_i` has priority in every state. The next state is IDLE, `start_o` and `res_valid_o` go low, `done_o` does not pulse, and any pending result is dropped.
- `go_i` together with `abort_i` in IDLE: abort wins and the scan does not start.

## Timing
- Reset values: `sel_o`=0, `start_o`=0, `stage_o`=0, `res_valid_o`=0, `res_idx_o`=0, `res_count_o`=0, `res_ovf_o`=0, `busy_o`=0, `done_o`=0.
- All outputs are registered.
- `busy_o` is high from the cycle after `go_i` until the cycle in which `done_o` pulses.
- SELECT lasts exactly max(settle,1) cycles. WARMUP lasts max(warmup,1) cycles. GATE lasts max(gate,1) cycles.
- `res_valid_o` rises on the first REPORT cycle. After the handshake cycle it is low for at least max(settle,1)+max(warmup,1)+max(gate,1)+1 cycles.
- Edge-to-count latency is 3 cycles. Edges detected after GATE ends are not counted.

## Configuration
- `RO_SCAN_SAT_EN` defined: the counter saturates at 2^COUNT_W−1, and `res_ovf_o` is set once that value is reached.
- `RO_SCAN_SAT_EN` not defined: the counter wraps modulo 2^COUNT_W, and `res_ovf_o` is set on any wrap. The reported count is the wrapped value.

## Structure
- Package `ro_scan_pkg`: the state enum, the IDX_W=log2(NUM_RO) constant, and the minimum wait constant (1).
- Sub-module `ro_edge_counter`: synchroniser, edge detect, counter and overflow flag. It has clear and enable inputs, and its own SAT_EN behaviour is driven by the macro.
- The top level holds the FSM, the wait/gate down-counter, the mask scan (priority find-next-set-bit) and the result register.

## Test plan
- Mask 0x0001, settle 2, warmup 4, gate 100, `ro_in_i` period 4 clk -> one result: idx 0, count 25 ±1, ovf 0, then `done_o`.
- Mask 0x8421, `res_ready_i` always 1 -> results with idx 0, 5, 10, 15 in that order, and `done_o` pulses exactly once.
- Mask 0x0003, `res_ready_i` held low for 50 cycles -> result 0 stays stable, `start_o` stays low, and the second measurement begins only after acceptance.
- COUNT_W=4, gate 100, `ro_in_i` period 4 -> with `RO_SCAN_SAT_EN`: count 15, ovf 1. Without it: count 25 mod 16 = 9, ovf 1.
- `abort_i` asserted mid-GATE -> next cycle in IDLE, `start_o`=0, `busy_o`=0, no `done_o`. A subsequent `go_i` scan completes normally.
- Mask 0x0000 with `go_i` -> `done_o` pulses, `start_o` never rises, no result is produced.
